// File: rtl/four_12_12_st3_out_buffer.sv
// Ping-pong frame buffer between the stage-3 output stream and stage 4.
// Frames are collected whole into one of two banks and only released
// downstream once every word of the frame has been captured.
module four_12_12_st3_out_buffer #(
    parameter int DATA_W    = 32,
    parameter int FRAME_LEN = 12,
    parameter int PTR_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_fst,
    input  logic              in_vld,
    output logic              in_rdy,
    output logic [DATA_W-1:0] out_data,
    output logic              out_fst,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic              frame_err,
    output logic [1:0]        frames_held
);

    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(FRAME_LEN - 1);
    localparam logic [PTR_W-1:0] ONE_IDX  = PTR_W'(1);

    typedef enum logic {
        WAIT_FST,
        FILL
    } wr_state_t;

    logic [DATA_W-1:0] mem [2][FRAME_LEN];
    logic [1:0]        full, full_nxt;
    logic              wb, wb_nxt;
    logic              rb, rb_nxt;
    logic [PTR_W-1:0]  wp, wp_nxt;
    logic [PTR_W-1:0]  rp, rp_nxt;
    wr_state_t         state, state_nxt;
    logic              wr_acc, rd_acc;
    logic              wr_en;
    logic [PTR_W-1:0]  wr_idx;
    logic              err_nxt;

    // Next-state for both the fill FSM and the read pointer; a restart
    // (fst inside a frame) always wins over completing the partial frame.
    always_comb begin
        state_nxt = state;
        wb_nxt    = wb;
        wp_nxt    = wp;
        rb_nxt    = rb;
        rp_nxt    = rp;
        full_nxt  = full;
        wr_en     = 1'b0;
        wr_idx    = wp;
        err_nxt   = 1'b0;
        wr_acc    = in_vld && in_rdy;
        rd_acc    = full[rb] && out_rdy;

        if (wr_acc) begin
            case (state)
                WAIT_FST: begin
                    if (in_fst) begin
                        wr_en     = 1'b1;
                        wr_idx    = '0;
                        wp_nxt    = ONE_IDX;
                        state_nxt = FILL;
                    end
                end
                FILL: begin
                    wr_en = 1'b1;
                    if (in_fst) begin
                        wr_idx  = '0;
                        wp_nxt  = ONE_IDX;
                        err_nxt = 1'b1;
                    end else if (wp == LAST_IDX) begin
                        full_nxt[wb] = 1'b1;
                        wb_nxt       = ~wb;
                        wp_nxt       = '0;
                        state_nxt    = WAIT_FST;
                    end else begin
                        wp_nxt = wp + ONE_IDX;
                    end
                end
            endcase
        end

        if (rd_acc) begin
            if (rp == LAST_IDX) begin
                full_nxt[rb] = 1'b0;
                rb_nxt       = ~rb;
                rp_nxt       = '0;
            end else begin
                rp_nxt = rp + ONE_IDX;
            end
        end
    end

    // Control registers; in_rdy and frames_held look ahead at the next
    // flags so a bank freed this cycle is writable on the very next one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= WAIT_FST;
            full        <= '0;
            wb          <= 1'b0;
            rb          <= 1'b0;
            wp          <= '0;
            rp          <= '0;
            in_rdy      <= 1'b0;
            frame_err   <= 1'b0;
            frames_held <= '0;
        end else begin
            state       <= state_nxt;
            full        <= full_nxt;
            wb          <= wb_nxt;
            rb          <= rb_nxt;
            wp          <= wp_nxt;
            rp          <= rp_nxt;
            in_rdy      <= !full_nxt[wb_nxt];
            frame_err   <= err_nxt;
            frames_held <= {1'b0, full_nxt[0]} + {1'b0, full_nxt[1]};
        end
    end

    // Bank storage; cleared on reset so out_data reads zero until refilled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int b = 0; b < 2; b++) begin
                for (int i = 0; i < FRAME_LEN; i++) begin
                    mem[b][i] <= '0;
                end
            end
        end else if (wr_en) begin
            mem[wb][wr_idx] <= in_data;
        end
    end

    assign out_vld  = full[rb];
    assign out_fst  = full[rb] && (rp == '0);
    assign out_data = mem[rb][rp];

endmodule

// File: tb/tb_four_12_12_st3_out_buffer.sv
// Self-checking bench for the stage-3 ping-pong output buffer.
// The reference model thinks in frames and word queues, not banks/pointers.
module tb_four_12_12_st3_out_buffer;

    localparam int DATA_W    = 32;
    localparam int FRAME_LEN = 12;

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] in_data;
    logic              in_fst;
    logic              in_vld;
    logic              in_rdy;
    logic [DATA_W-1:0] out_data;
    logic              out_fst;
    logic              out_vld;
    logic              out_rdy;
    logic              frame_err;
    logic [1:0]        frames_held;

    int n_checks;
    int n_fail;

    logic [32:0] src_q[$];
    logic [31:0] out_q[$];
    logic [31:0] asm_q[$];
    bit          in_frame;
    bit          rdy_m;
    bit          err_m;
    bit          last_acc;

    four_12_12_st3_out_buffer #(
        .DATA_W(DATA_W),
        .FRAME_LEN(FRAME_LEN),
        .PTR_W(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in_data(in_data),
        .in_fst(in_fst),
        .in_vld(in_vld),
        .in_rdy(in_rdy),
        .out_data(out_data),
        .out_fst(out_fst),
        .out_vld(out_vld),
        .out_rdy(out_rdy),
        .frame_err(frame_err),
        .frames_held(frames_held)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int held_m();
        return (out_q.size() + FRAME_LEN - 1) / FRAME_LEN;
    endfunction

    function automatic bit exp_vld();
        return out_q.size() != 0;
    endfunction

    function automatic bit exp_fst();
        return (out_q.size() != 0) && ((out_q.size() % FRAME_LEN) == 0);
    endfunction

    function automatic logic [31:0] exp_data();
        return (out_q.size() != 0) ? out_q[0] : 32'h0;
    endfunction

    task automatic model_reset();
        out_q.delete();
        asm_q.delete();
        src_q.delete();
        in_frame = 1'b0;
        rdy_m    = 1'b0;
        err_m    = 1'b0;
    endtask

    // Frame-level model: a frame becomes readable only once all its words
    // are in; the buffer can hold at most two undelivered frames.
    task automatic model_edge();
        bit acc;
        acc      = in_vld && rdy_m;
        last_acc = acc;
        err_m    = 1'b0;
        if (out_q.size() != 0 && out_rdy) void'(out_q.pop_front());
        if (acc) begin
            if (in_fst) begin
                if (in_frame) err_m = 1'b1;
                asm_q.delete();
                asm_q.push_back(in_data);
                in_frame = 1'b1;
            end else if (in_frame) begin
                asm_q.push_back(in_data);
            end
            if (in_frame && asm_q.size() == FRAME_LEN) begin
                foreach (asm_q[i]) out_q.push_back(asm_q[i]);
                asm_q.delete();
                in_frame = 1'b0;
            end
        end
        rdy_m = held_m() < 2;
    endtask

    task automatic push_word(input bit f, input logic [31:0] d);
        src_q.push_back({f, d});
    endtask

    task automatic drive(input bit vld_en, input bit ordy);
        logic [32:0] w;
        w       = (src_q.size() != 0) ? src_q[0] : 33'h0;
        in_vld  = vld_en && (src_q.size() != 0);
        in_fst  = w[32];
        in_data = w[31:0];
        out_rdy = ordy;
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        if (last_acc) void'(src_q.pop_front());
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(1'b0, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_in_rdy: got %b expected 0", in_rdy); end
        n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_vld: got %b expected 0", out_vld); end
        n_checks++; if (out_fst !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_out_fst: got %b expected 0", out_fst); end
        n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("[TB] FAIL reset_out_data: got %h expected 0", out_data); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
        n_checks++; if (frames_held !== 2'd0) begin n_fail++; $display("[TB] FAIL reset_frames_held: got %0d expected 0", frames_held); end
        reset = 1'b1;
        tick();
        n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_release_in_rdy: got %b expected 1", in_rdy); end
    endtask

    task automatic test_single_frame();
        int fst_seen;
        int words_seen;
        bit done;
        fst_seen   = 0;
        words_seen = 0;
        done       = 1'b0;
        for (int i = 1; i <= FRAME_LEN; i++) push_word(i == 1, 32'(i));
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            n_checks++; if (out_vld !== exp_vld()) begin n_fail++; $display("[TB] FAIL single_out_vld: got %b expected %b", out_vld, exp_vld()); end
            n_checks++; if (frames_held !== 2'(held_m())) begin n_fail++; $display("[TB] FAIL single_frames_held: got %0d expected %0d", frames_held, held_m()); end
            if (exp_vld()) begin
                n_checks++; if (out_data !== exp_data()) begin n_fail++; $display("[TB] FAIL single_out_data: got %h expected %h", out_data, exp_data()); end
                n_checks++; if (out_fst !== exp_fst()) begin n_fail++; $display("[TB] FAIL single_out_fst: got %b expected %b", out_fst, exp_fst()); end
            end
            if (out_vld === 1'b1) words_seen++;
            if (out_fst === 1'b1) fst_seen++;
            drive(1'b1, 1'b1);
            tick();
            done = (src_q.size() == 0) && (out_q.size() == 0);
        end
        n_checks++; if (!done) begin n_fail++; $display("[TB] FAIL single_timeout: got pending=%0d expected 0", out_q.size()); end
        n_checks++; if (words_seen != FRAME_LEN) begin n_fail++; $display("[TB] FAIL single_word_count: got %0d expected %0d", words_seen, FRAME_LEN); end
        n_checks++; if (fst_seen != 1) begin n_fail++; $display("[TB] FAIL single_fst_count: got %0d expected 1", fst_seen); end
        n_checks++; if (frames_held !== 2'd0) begin n_fail++; $display("[TB] FAIL single_final_held: got %0d expected 0", frames_held); end
    endtask

    task automatic test_backpressure();
        bit done;
        done = 1'b0;
        for (int f = 0; f < 3; f++)
            for (int i = 0; i < FRAME_LEN; i++) push_word(i == 0, $urandom);
        for (int cyc = 0; cyc < 40; cyc++) begin
            n_checks++; if (in_rdy !== rdy_m) begin n_fail++; $display("[TB] FAIL bp_in_rdy: got %b expected %b", in_rdy, rdy_m); end
            n_checks++; if (out_vld !== exp_vld()) begin n_fail++; $display("[TB] FAIL bp_out_vld: got %b expected %b", out_vld, exp_vld()); end
            drive(1'b1, 1'b0);
            tick();
        end
        n_checks++; if (frames_held !== 2'd2) begin n_fail++; $display("[TB] FAIL bp_frames_held: got %0d expected 2", frames_held); end
        n_checks++; if (in_rdy !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_stalled_in_rdy: got %b expected 0", in_rdy); end
        n_checks++; if (src_q.size() != FRAME_LEN) begin n_fail++; $display("[TB] FAIL bp_third_frame_waiting: got %0d expected %0d", src_q.size(), FRAME_LEN); end
        for (int cyc = 0; cyc < 150 && !done; cyc++) begin
            n_checks++; if (in_rdy !== rdy_m) begin n_fail++; $display("[TB] FAIL bp_drain_in_rdy: got %b expected %b", in_rdy, rdy_m); end
            n_checks++; if (out_vld !== exp_vld()) begin n_fail++; $display("[TB] FAIL bp_drain_out_vld: got %b expected %b", out_vld, exp_vld()); end
            n_checks++; if (frames_held !== 2'(held_m())) begin n_fail++; $display("[TB] FAIL bp_drain_held: got %0d expected %0d", frames_held, held_m()); end
            if (exp_vld()) begin
                n_checks++; if (out_data !== exp_data()) begin n_fail++; $display("[TB] FAIL bp_out_data: got %h expected %h", out_data, exp_data()); end
                n_checks++; if (out_fst !== exp_fst()) begin n_fail++; $display("[TB] FAIL bp_out_fst: got %b expected %b", out_fst, exp_fst()); end
            end
            drive(1'b1, 1'b1);
            tick();
            done = (src_q.size() == 0) && (out_q.size() == 0);
        end
        n_checks++; if (!done) begin n_fail++; $display("[TB] FAIL bp_timeout: got pending=%0d expected 0", out_q.size() + src_q.size()); end
    endtask

    task automatic test_restart();
        int err_seen;
        int words_seen;
        bit done;
        err_seen   = 0;
        words_seen = 0;
        done       = 1'b0;
        for (int i = 0; i < 4; i++) push_word(i == 0, 32'hDEAD_0000 + 32'(i));
        for (int i = 0; i < FRAME_LEN; i++) push_word(i == 0, 32'hBEEF_0000 + 32'(i));
        for (int cyc = 0; cyc < 80 && !done; cyc++) begin
            n_checks++; if (frame_err !== err_m) begin n_fail++; $display("[TB] FAIL restart_frame_err: got %b expected %b", frame_err, err_m); end
            n_checks++; if (out_vld !== exp_vld()) begin n_fail++; $display("[TB] FAIL restart_out_vld: got %b expected %b", out_vld, exp_vld()); end
            if (exp_vld()) begin
                n_checks++; if (out_data !== exp_data()) begin n_fail++; $display("[TB] FAIL restart_out_data: got %h expected %h", out_data, exp_data()); end
                n_checks++; if (out_fst !== exp_fst()) begin n_fail++; $display("[TB] FAIL restart_out_fst: got %b expected %b", out_fst, exp_fst()); end
            end
            if (frame_err === 1'b1) err_seen++;
            if (out_vld === 1'b1) words_seen++;
            drive(1'b1, 1'b1);
            tick();
            done = (src_q.size() == 0) && (out_q.size() == 0) && !err_m;
        end
        n_checks++; if (!done) begin n_fail++; $display("[TB] FAIL restart_timeout: got pending=%0d expected 0", out_q.size()); end
        n_checks++; if (err_seen != 1) begin n_fail++; $display("[TB] FAIL restart_err_pulses: got %0d expected 1", err_seen); end
        n_checks++; if (words_seen != FRAME_LEN) begin n_fail++; $display("[TB] FAIL restart_word_count: got %0d expected %0d", words_seen, FRAME_LEN); end
    endtask

    task automatic test_no_fst();
        for (int i = 0; i < 10; i++) push_word(1'b0, $urandom);
        for (int cyc = 0; cyc < 20; cyc++) begin
            n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("[TB] FAIL nofst_out_vld: got %b expected 0", out_vld); end
            n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL nofst_frame_err: got %b expected 0", frame_err); end
            n_checks++; if (in_rdy !== rdy_m) begin n_fail++; $display("[TB] FAIL nofst_in_rdy: got %b expected %b", in_rdy, rdy_m); end
            drive(1'b1, 1'b1);
            tick();
        end
        n_checks++; if (src_q.size() != 0) begin n_fail++; $display("[TB] FAIL nofst_words_taken: got %0d left expected 0", src_q.size()); end
    endtask

    task automatic test_back_to_back();
        int first_out;
        int last_out;
        int out_cycles;
        int accept_done;
        bit done;
        first_out   = -1;
        last_out    = -1;
        out_cycles  = 0;
        accept_done = -1;
        done        = 1'b0;
        for (int f = 0; f < 4; f++)
            for (int i = 0; i < FRAME_LEN; i++) push_word(i == 0, $urandom);
        for (int cyc = 0; cyc < 120 && !done; cyc++) begin
            n_checks++; if (in_rdy !== 1'b1) begin n_fail++; $display("[TB] FAIL b2b_in_rdy: got %b expected 1", in_rdy); end
            n_checks++; if (frames_held !== 2'(held_m())) begin n_fail++; $display("[TB] FAIL b2b_frames_held: got %0d expected %0d", frames_held, held_m()); end
            if (exp_vld()) begin
                n_checks++; if (out_data !== exp_data()) begin n_fail++; $display("[TB] FAIL b2b_out_data: got %h expected %h", out_data, exp_data()); end
            end
            if (out_vld === 1'b1) begin
                if (first_out < 0) first_out = cyc;
                last_out = cyc;
                out_cycles++;
            end
            drive(1'b1, 1'b1);
            tick();
            if (src_q.size() == 0 && accept_done < 0) accept_done = cyc + 1;
            done = (src_q.size() == 0) && (out_q.size() == 0);
        end
        n_checks++; if (!done) begin n_fail++; $display("[TB] FAIL b2b_timeout: got pending=%0d expected 0", out_q.size()); end
        n_checks++; if (accept_done != 4 * FRAME_LEN) begin n_fail++; $display("[TB] FAIL b2b_input_cycles: got %0d expected %0d", accept_done, 4 * FRAME_LEN); end
        n_checks++; if (out_cycles != 4 * FRAME_LEN) begin n_fail++; $display("[TB] FAIL b2b_output_words: got %0d expected %0d", out_cycles, 4 * FRAME_LEN); end
        n_checks++; if (last_out - first_out != 4 * FRAME_LEN - 1) begin n_fail++; $display("[TB] FAIL b2b_output_span: got %0d expected %0d", last_out - first_out, 4 * FRAME_LEN - 1); end
    endtask

    task automatic test_reset_mid();
        bit done;
        done = 1'b0;
        for (int i = 0; i < FRAME_LEN; i++) push_word(i == 0, $urandom);
        for (int cyc = 0; cyc < 60 && !(out_q.size() == FRAME_LEN - 6 && src_q.size() == 0); cyc++) begin
            drive(1'b1, 1'b1);
            tick();
        end
        n_checks++; if (out_data !== exp_data()) begin n_fail++; $display("[TB] FAIL midrst_word6: got %h expected %h", out_data, exp_data()); end
        n_checks++; if (out_vld !== 1'b1) begin n_fail++; $display("[TB] FAIL midrst_pre_vld: got %b expected 1", out_vld); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_out_vld: got %b expected 0", out_vld); end
        n_checks++; if (frames_held !== 2'd0) begin n_fail++; $display("[TB] FAIL midrst_frames_held: got %0d expected 0", frames_held); end
        model_reset();
        drive(1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) push_word(1'b0, $urandom);
        for (int cyc = 0; cyc < 8; cyc++) begin
            n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_quiet_vld: got %b expected 0", out_vld); end
            drive(1'b1, 1'b1);
            tick();
        end
        for (int i = 0; i < FRAME_LEN; i++) push_word(i == 0, $urandom);
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            n_checks++; if (out_vld !== exp_vld()) begin n_fail++; $display("[TB] FAIL midrst_new_vld: got %b expected %b", out_vld, exp_vld()); end
            if (exp_vld()) begin
                n_checks++; if (out_data !== exp_data()) begin n_fail++; $display("[TB] FAIL midrst_new_data: got %h expected %h", out_data, exp_data()); end
            end
            drive(1'b1, 1'b1);
            tick();
            done = (src_q.size() == 0) && (out_q.size() == 0);
        end
        n_checks++; if (!done) begin n_fail++; $display("[TB] FAIL midrst_timeout: got pending=%0d expected 0", out_q.size()); end
    endtask

    task automatic test_random();
        bit done;
        done = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (src_q.size() == 0) push_word($urandom_range(0, 7) == 0, $urandom);
            n_checks++; if (in_rdy !== rdy_m) begin n_fail++; $display("[TB] FAIL rand_in_rdy: got %b expected %b", in_rdy, rdy_m); end
            n_checks++; if (out_vld !== exp_vld()) begin n_fail++; $display("[TB] FAIL rand_out_vld: got %b expected %b", out_vld, exp_vld()); end
            n_checks++; if (frames_held !== 2'(held_m())) begin n_fail++; $display("[TB] FAIL rand_frames_held: got %0d expected %0d", frames_held, held_m()); end
            n_checks++; if (frame_err !== err_m) begin n_fail++; $display("[TB] FAIL rand_frame_err: got %b expected %b", frame_err, err_m); end
            if (exp_vld()) begin
                n_checks++; if (out_data !== exp_data()) begin n_fail++; $display("[TB] FAIL rand_out_data: got %h expected %h", out_data, exp_data()); end
                n_checks++; if (out_fst !== exp_fst()) begin n_fail++; $display("[TB] FAIL rand_out_fst: got %b expected %b", out_fst, exp_fst()); end
            end
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) < 3);
            tick();
        end
        src_q.delete();
        for (int cyc = 0; cyc < 60 && !done; cyc++) begin
            n_checks++; if (out_vld !== exp_vld()) begin n_fail++; $display("[TB] FAIL rand_drain_vld: got %b expected %b", out_vld, exp_vld()); end
            if (exp_vld()) begin
                n_checks++; if (out_data !== exp_data()) begin n_fail++; $display("[TB] FAIL rand_drain_data: got %h expected %h", out_data, exp_data()); end
            end
            drive(1'b0, 1'b1);
            tick();
            done = out_q.size() == 0;
        end
        n_checks++; if (!done) begin n_fail++; $display("[TB] FAIL rand_timeout: got pending=%0d expected 0", out_q.size()); end
    endtask

    // Scenario sequence
    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_single_frame();
        test_backpressure();
        test_restart();
        test_no_fst();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
